// File: rtl/codec_i2c_init.sv
// Autonomous I2C write master: after start_i, walks the register table and writes
// each entry to the codec as {dev,w} / {addr,d8} / d[7:0], then reports done/ack_err.
module codec_i2c_init #(
  parameter int          CLK_FREQ = 25000000,
  parameter int          I2C_FREQ = 100000,
  parameter logic [6:0]  DEV_ADDR = 7'h1A,
  parameter int          NUM_REGS = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [7:0]  tbl_idx_o,
  input  logic [15:0] tbl_data_i,
  output logic        scl_oe_o,
  output logic        sda_oe_o,
  input  logic        sda_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        ack_err_o
);
  localparam int             Q        = CLK_FREQ / (4 * I2C_FREQ);
  localparam int             CW       = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [CW-1:0]  RELOAD   = CW'(Q - 1);
  localparam logic [7:0]     LAST_IDX = 8'(NUM_REGS - 1);

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, GAP, DONE} state_t;
  state_t state, state_d;

  logic [CW-1:0] cnt;
  logic [1:0]    phase;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [23:0]   dat;
  logic          sda_s1, sda_s2;
  logic          tick, last_ph, go;

  assign go      = start_i && (state == IDLE || state == DONE);
  assign tick    = (state != IDLE) && (cnt == '0);
  assign last_ph = tick && (phase == 2'd3);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: if (start_i) state_d = START;
      START:      if (last_ph) state_d = BIT;
      BIT:        if (last_ph && bit_cnt == 3'd7) state_d = ACK;
      ACK:        if (last_ph) state_d = (sda_s2 || byte_cnt == 2'd2) ? STOP : BIT;
      STOP:       if (last_ph) state_d = ack_err_o ? DONE : GAP;
      GAP:        if (last_ph) state_d = (tbl_idx_o == LAST_IDX) ? DONE : START;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt       <= RELOAD;
      phase     <= 2'd0;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 2'd0;
      dat       <= 24'd0;
      sda_s1    <= 1'b1;
      sda_s2    <= 1'b1;
      tbl_idx_o <= 8'd0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      ack_err_o <= 1'b0;
    end else begin
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;

      if (state == IDLE || go || tick) cnt <= RELOAD;
      else                             cnt <= cnt - 1'b1;

      if (go)        phase <= 2'd0;
      else if (tick) phase <= phase + 2'd1;

      // Entry is re-captured for the whole START so the ROM has settled on the new index.
      if (state == START) begin
        dat      <= {DEV_ADDR, 1'b0, tbl_data_i};
        bit_cnt  <= 3'd0;
        byte_cnt <= 2'd0;
      end else if (state == BIT && last_ph) begin
        dat     <= {dat[22:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end else if (state == ACK && last_ph) begin
        byte_cnt <= byte_cnt + 2'd1;
      end

      if (go) begin
        tbl_idx_o <= 8'd0;
        busy_o    <= 1'b1;
        done_o    <= 1'b0;
        ack_err_o <= 1'b0;
      end else begin
        if (state == ACK && last_ph && sda_s2) ack_err_o <= 1'b1;
        if (state == GAP && state_d == START)  tbl_idx_o <= tbl_idx_o + 8'd1;
        if (state != DONE && state_d == DONE) begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
      end
    end
  end

  // SCL falls on phase 0 of every bit slot, so SDA only moves while SCL is low.
  always_comb begin
    scl_oe_o = 1'b0;
    sda_oe_o = 1'b0;
    case (state)
      START: begin
        sda_oe_o = (phase != 2'd0);
        scl_oe_o = (phase == 2'd3);
      end
      BIT: begin
        scl_oe_o = ~phase[1];
        sda_oe_o = ~dat[23];
      end
      ACK:  scl_oe_o = ~phase[1];
      STOP: begin
        scl_oe_o = (phase == 2'd0);
        sda_oe_o = ~phase[1];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_codec_i2c_init.sv
// Bench for codec_i2c_init: I2C slave/bus decoder monitor checks the decoded event
// stream against a queue filled by a table-level reference model, plus timing and flags.
`timescale 1ns/1ps
module tb_codec_i2c_init;
  localparam int         CLK_FREQ = 4000000;
  localparam int         I2C_FREQ = 100000;
  localparam int         Q        = CLK_FREQ / (4 * I2C_FREQ);
  localparam int         NUM      = 3;
  localparam logic [6:0] DEV      = 7'h1A;
  localparam int EV_START = 256, EV_STOP = 512, EV_ACK = 768;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, slave_pull = 1'b0;
  logic [7:0]  tbl_idx;
  logic [15:0] tbl_data;
  logic        scl_oe, sda_oe, busy, done, ack_err;
  logic [15:0] rom [256];
  logic [6:0]  ra [NUM];
  logic [8:0]  rd [NUM];
  wire scl_line = ~scl_oe;
  wire sda_line = ~(sda_oe | slave_pull);
  assign tbl_data = rom[tbl_idx];

  int total = 0, bad = 0, cyc = 0, mon_bytes = 0, nack_abs = -1;
  int exp_q [$];

  codec_i2c_init #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ), .DEV_ADDR(DEV), .NUM_REGS(NUM)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .tbl_idx_o(tbl_idx), .tbl_data_i(tbl_data),
    .scl_oe_o(scl_oe), .sda_oe_o(sda_oe), .sda_i(sda_line),
    .busy_o(busy), .done_o(done), .ack_err_o(ack_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic emit(input int ev);
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL event_unexpected: got %0h want none (cycle %0d)", ev, cyc);
    end else check("event", ev, exp_q.pop_front());
  endtask

  // Bus decoder and ACKing slave
  bit         in_frame = 0, skip = 0;
  int         bitcnt = 0, rises = 0, t_rise = 0, t_fall = 0, low_w = 0;
  logic [7:0] sr = 8'd0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      in_frame = 0; bitcnt = 0; slave_pull = 1'b0; skip = 1;
    end else if (skip) begin
      skip = 0;
    end else begin
      if (prev_scl && scl_line && sda_line != prev_sda) begin
        if (!sda_line) begin
          check("start_after_stop", int'(in_frame), 0);
          emit(EV_START);
          in_frame = 1; bitcnt = 0; rises = 0; slave_pull = 1'b0;
        end else begin
          // the STOP is preceded by one SCL rise that looks like a bit start
          check("stop_bitpos", bitcnt, 1);
          emit(EV_STOP);
          in_frame = 0; bitcnt = 0;
        end
      end
      if (!prev_scl && scl_line && in_frame) begin
        rises++; t_rise = cyc; low_w = cyc - t_fall;
        if (bitcnt < 8) begin
          sr = {sr[6:0], sda_line}; bitcnt++;
          if (bitcnt == 8) emit(int'(sr));
        end else begin
          emit(EV_ACK + int'(sda_line));
          bitcnt = 0; mon_bytes++;
        end
      end
      if (prev_scl && !scl_line) begin
        if (in_frame && rises > 0) check("scl_high_w", cyc - t_rise, 2 * Q);
        if (in_frame && rises > 1) check("scl_low_w", low_w, 2 * Q);
        t_fall = cyc;
        slave_pull = (in_frame && bitcnt == 8 && mon_bytes != nack_abs);
      end
    end
    prev_scl = scl_line; prev_sda = sda_line;
  end

  task automatic set_tbl(input int i, input logic [6:0] a, input logic [8:0] d);
    ra[i] = a; rd[i] = d; rom[i] = {a, d};
  endtask

  // Reference: expected bus events, run length and final flags for a run
  task automatic model(input int nack_at, output int exp_cyc, output int exp_idx, output int exp_err);
    int b [3];
    int k;
    k = 0;
    exp_cyc = NUM * 120 * Q + 1; exp_idx = NUM - 1; exp_err = 0;
    for (int e = 0; e < NUM; e++) begin
      b[0] = int'(DEV) * 2;
      b[1] = int'(ra[e]) * 2 + int'(rd[e]) / 256;
      b[2] = int'(rd[e]) % 256;
      exp_q.push_back(EV_START);
      for (int j = 0; j < 3; j++) begin
        exp_q.push_back(b[j]);
        exp_q.push_back(EV_ACK + ((k == nack_at) ? 1 : 0));
        if (k == nack_at) begin
          exp_q.push_back(EV_STOP);
          exp_cyc = (e * 120 + 4 + 36 * (j + 1) + 4) * Q + 1;
          exp_idx = e; exp_err = 1;
          return;
        end
        k++;
      end
      exp_q.push_back(EV_STOP);
    end
  endtask

  task automatic do_run(input int nack_at, input bit poke, input bit rst_mid);
    int exp_cyc, exp_idx, exp_err, n, poke_at;
    model(nack_at, exp_cyc, exp_idx, exp_err);
    nack_abs = (nack_at < 0) ? -1 : mon_bytes + nack_at;
    poke_at  = poke ? int'($urandom_range(50, 400)) : -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; n = 1;
    check("busy_on_start", int'(busy), 1);
    check("done_cleared", int'(done), 0);
    check("err_cleared", int'(ack_err), 0);
    if (rst_mid) begin
      repeat ($urandom_range(45, 355)) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("rst_scl_oe", int'(scl_oe), 0);
      check("rst_sda_oe", int'(sda_oe), 0);
      check("rst_busy", int'(busy), 0);
      repeat (50) @(posedge clk);
      return;
    end
    while (!done && n < 5000) begin
      @(posedge clk); #1;
      n++;
      start = (n == poke_at);
    end
    start = 1'b0;
    check("run_cycles", n, exp_cyc);
    check("ack_err", int'(ack_err), exp_err);
    check("tbl_idx_end", int'(tbl_idx), exp_idx);
    check("busy_end", int'(busy), 0);
    check("events_left", exp_q.size(), 0);
    repeat (20) @(posedge clk);
    #1 check("bus_idle", int'({scl_oe, sda_oe}), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", int'(scl_oe), 0);
    check("rst_sda", int'(sda_oe), 0);
    check("rst_busy0", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(ack_err), 0);
    check("rst_idx", int'(tbl_idx), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    set_tbl(0, 7'h0E, 9'h002); set_tbl(1, 7'h0A, 9'h1FF); set_tbl(2, 7'h2A, 9'h00F);
    do_run(-1, 0, 0);
    set_tbl(0, 7'h0F, 9'h000);
    do_run(1, 0, 0);
    do_run(-1, 0, 1);
    do_run(-1, 0, 0);
    do_run(-1, 1, 0);
    repeat (5) begin
      for (int i = 0; i < NUM; i++) set_tbl(i, 7'($urandom), 9'($urandom));
      do_run($urandom_range(0, 1) ? -1 : int'($urandom_range(0, 3 * NUM - 1)), 1'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
